// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory command encoding, address map and widths.
package cpu_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned RAM_AW = 8;
    localparam int unsigned IO_W   = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_t;

    localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
    localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

    // RAM occupies the lower half of the word address space
    function automatic logic is_ram(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1] == 1'b0;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port RAM: synchronous write, registered read, no reset on contents.
module ram_sp #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU memory/IO bridge: RAM, LED register and synchronized switches behind a
// small command FSM with a two-edge read latency.
module mem_io_bridge
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              rd_valid,
    output logic              busy,
    input  logic [IO_W-1:0]   sw,
    output logic [IO_W-1:0]   ledr,
    output logic              err,
    output logic [CNT_W-1:0]  access_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        RD_DONE = 2'b10,
        WR      = 2'b11
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [IO_W-1:0]     sw_meta;
    logic [IO_W-1:0]     sw_sync;
    logic [DATA_W-1:0]   ram_rdata;
    logic [RAM_AW-1:0]   ram_addr_c;
    logic                ram_we_c;
    logic                led_we_c;
    logic                err_set_c;
    logic                cnt_inc_c;
    logic                rd_load_c;
    logic [DATA_W-1:0]   rd_mux_c;

    ram_sp #(
        .AW (RAM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c & ~reset),
        .addr  (ram_addr_c),
        .wdata (write_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In IDLE the RAM is addressed straight from the bus so the registered
    // read is ready by the time RD_WAIT is left.
    always_comb begin
        state_nxt  = state;
        ram_addr_c = addr_q[RAM_AW-1:0];
        ram_we_c   = 1'b0;
        led_we_c   = 1'b0;
        err_set_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        rd_load_c  = 1'b0;
        unique case (state)
            IDLE: begin
                ram_addr_c = mem_addr[RAM_AW-1:0];
                if (mem_cmd == MREAD) begin
                    state_nxt = RD_WAIT;
                end else if (mem_cmd == MWRITE) begin
                    state_nxt = WR;
                    cnt_inc_c = 1'b1;
                    if (is_ram(mem_addr)) begin
                        ram_we_c = 1'b1;
                    end else if (mem_addr == LED_ADDR) begin
                        led_we_c = 1'b1;
                    end else begin
                        err_set_c = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                state_nxt = RD_DONE;
                cnt_inc_c = 1'b1;
                rd_load_c = 1'b1;
                if (!is_ram(addr_q) && addr_q != SW_ADDR) begin
                    err_set_c = 1'b1;
                end
            end
            RD_DONE: state_nxt = IDLE;
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux_c = '0;
        if (is_ram(addr_q)) begin
            rd_mux_c = ram_rdata;
        end else if (addr_q == SW_ADDR) begin
            rd_mux_c = DATA_W'(sw_sync);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            read_data  <= '0;
            rd_valid   <= 1'b0;
            busy       <= 1'b0;
            ledr       <= '0;
            err        <= 1'b0;
            access_cnt <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            rd_valid <= (state_nxt == RD_DONE);
            busy     <= (state_nxt != IDLE);
            if (state == IDLE) begin
                addr_q <= mem_addr;
            end
            if (rd_load_c) begin
                read_data <= rd_mux_c;
            end
            if (led_we_c) begin
                ledr <= write_data[IO_W-1:0];
            end
            if (err_set_c) begin
                err <= 1'b1;
            end
            if (cnt_inc_c) begin
                access_cnt <= access_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: directed transactions, read results
// checked by an independent monitor on rd_valid.
module tb_mem_io_bridge;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_valid;
    logic        busy;
    logic [7:0]  sw;
    logic [7:0]  ledr;
    logic        err;
    logic [15:0] access_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    mem_io_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .sw         (sw),
        .ledr       (ledr),
        .err        (err),
        .access_cnt (access_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected read
    always @(negedge clk) begin : monitor
        logic [15:0] e;
        if (reset === 1'b0 && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got read_data 0x%0h expected no response", read_data);
            end else begin
                e = exp_q.pop_front();
                check("read_data", 32'(read_data), 32'(e));
            end
        end
    end

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = MWRITE;
        mem_addr   = a;
        write_data = d;
        step();
        mem_cmd = MNONE;
        exp_cnt = exp_cnt + 16'd1;
        check("wr_busy", 32'(busy), 32'h1);
        step();
        check("wr_idle", 32'(busy), 32'h0);
    endtask

    task automatic rd(input logic [8:0] a, input logic [15:0] e);
        exp_q.push_back(e);
        mem_cmd  = MREAD;
        mem_addr = a;
        step();
        mem_cmd = MNONE;
        check("rd_valid_early", 32'(rd_valid), 32'h0);
        step();
        exp_cnt = exp_cnt + 16'd1;
        check("rd_valid_pulse", 32'(rd_valid), 32'h1);
        step();
        check("rd_valid_drop", 32'(rd_valid), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        mem_cmd    = MNONE;
        mem_addr   = '0;
        write_data = '0;
        sw         = '0;
        exp_cnt    = '0;
        repeat (2) step();
        reset = 1'b0;
        check("rst_read_data", 32'(read_data), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ledr", 32'(ledr), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_access_cnt", 32'(access_cnt), 32'h0);

        // RAM write then read back
        wr(9'h005, 16'hBEEF);
        rd(9'h005, 16'hBEEF);
        check("access_cnt_2", 32'(access_cnt), 32'h2);
        check("err_clean", 32'(err), 32'h0);

        // LED write, then illegal read of the write-only LED
        wr(9'h100, 16'h12A5);
        check("ledr_a5", 32'(ledr), 32'hA5);
        check("err_after_led_wr", 32'(err), 32'h0);
        rd(9'h100, 16'h0000);
        check("err_led_rd", 32'(err), 32'h1);

        // Switch read through synchronizer; illegal switch write
        sw = 8'h3C;
        repeat (3) step();
        rd(9'h140, 16'h003C);
        wr(9'h040, 16'h4040);
        wr(9'h140, 16'hFFFF);
        check("ledr_kept", 32'(ledr), 32'hA5);
        check("err_sticky", 32'(err), 32'h1);
        rd(9'h040, 16'h4040);

        // Bus changes during RD_WAIT are ignored
        wr(9'h010, 16'h1111);
        wr(9'h011, 16'h2222);
        exp_q.push_back(16'h1111);
        mem_cmd  = MREAD;
        mem_addr = 9'h010;
        step();
        mem_cmd    = MWRITE;
        mem_addr   = 9'h011;
        write_data = 16'hDEAD;
        step();
        mem_cmd = MNONE;
        exp_cnt = exp_cnt + 16'd1;
        step();
        repeat (3) step();
        check("read_data_hold", 32'(read_data), 32'h1111);
        rd(9'h011, 16'h2222);

        // Held MREAD gives back-to-back 3-cycle reads
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h2222);
        mem_cmd  = MREAD;
        mem_addr = 9'h011;
        step();
        check("b2b_busy_1", 32'(busy), 32'h1);
        step();
        step();
        check("b2b_idle_gap", 32'(busy), 32'h0);
        step();
        check("b2b_busy_2", 32'(busy), 32'h1);
        step();
        mem_cmd = MNONE;
        step();
        exp_cnt = exp_cnt + 16'd2;
        check("b2b_access_cnt", 32'(access_cnt), 32'(exp_cnt));

        // Reset in RD_WAIT aborts the read; RAM survives
        mem_cmd  = MREAD;
        mem_addr = 9'h005;
        step();
        mem_cmd = MNONE;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        exp_cnt = '0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_rd_valid", 32'(rd_valid), 32'h0);
        check("abort_read_data", 32'(read_data), 32'h0);
        check("abort_err", 32'(err), 32'h0);
        check("abort_ledr", 32'(ledr), 32'h0);
        check("abort_access_cnt", 32'(access_cnt), 32'h0);
        rd(9'h005, 16'hBEEF);
        check("post_abort_cnt", 32'(access_cnt), 32'(exp_cnt));

        // Counter wrap: 65535 held writes, then one more
        reset = 1'b1;
        step();
        reset      = 1'b0;
        exp_cnt    = '0;
        mem_cmd    = MWRITE;
        mem_addr   = 9'h000;
        write_data = 16'h7777;
        repeat (2 * 65535) step();
        mem_cmd = MNONE;
        check("cnt_ffff", 32'(access_cnt), 32'hFFFF);
        wr(9'h000, 16'h1234);
        check("cnt_wrap", 32'(access_cnt), 32'h0);
        check("wrap_err", 32'(err), 32'h0);

        step();
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port mem_cmd, input, 2 bits: CPU memory command (MNONE, MREAD, MWRITE).
REQ-004 The block SHALL have port mem_addr, input, 9 bits: CPU word address.
REQ-005 The block SHALL have port write_data, input, 16 bits: CPU datapath output used as store data.
REQ-006 The block SHALL have port read_data, output, 16 bits: registered load data to the CPU instruction/data input.
REQ-007 The block SHALL have port rd_valid, output, 1 bit: high for exactly one cycle when read_data holds a new result.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port sw, input, 8 bits: asynchronous board switches.
REQ-010 The block SHALL have port ledr, output, 8 bits: LED register.
REQ-011 The block SHALL have port err, output, 1 bit: sticky flag for an illegal access.
REQ-012 The block SHALL have port access_cnt, output, 16 bits: count of completed transactions.

Function
REQ-013 Memory map SHALL be: 0x000-0x0FF RAM (256x16); 0x100 LED (write-only, low 8 bits); 0x140 switches (read-only, zero-extended to 16 bits); all other addresses unmapped.
REQ-014 The FSM SHALL have states IDLE, RD_WAIT, RD_DONE and WR.
REQ-015 mem_cmd and mem_addr SHALL be sampled only in IDLE; the address SHALL be captured into an internal register at that edge.
REQ-016 IDLE with MREAD SHALL transition to RD_WAIT, then RD_WAIT to RD_DONE unconditionally, then RD_DONE to IDLE.
REQ-017 The edge leaving RD_WAIT SHALL load read_data; rd_valid SHALL be 1 only in RD_DONE, giving a read latency of 2 edges from command sample to valid data.
REQ-018 read_data SHALL hold its value until the next read completes.
REQ-019 IDLE with MWRITE SHALL perform the write at the sampling edge (RAM word or ledr<=write_data[7:0]) and transition to WR, which SHALL return to IDLE at the next edge.
REQ-020 IDLE with MNONE or the unused encoding SHALL remain in IDLE with no side effects.
REQ-021 Changes on mem_cmd, mem_addr or write_data during RD_WAIT, RD_DONE or WR SHALL be ignored; the captured transaction SHALL complete unchanged.
REQ-022 A command still asserted on return to IDLE SHALL start a new transaction, so back-to-back reads take 3 cycles each.
REQ-023 A read of an unmapped address SHALL return 0x0000 and set err.
REQ-024 A write to an unmapped address or to 0x140 SHALL change no state except setting err.
REQ-025 err SHALL stay set until reset.
REQ-026 sw SHALL pass through a 2-flop synchronizer, and reads of 0x140 SHALL return the synchronized value.
REQ-027 access_cnt SHALL increment by 1 on entry to RD_DONE or WR, including unmapped accesses, and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-028 When reset is high at an edge, reset SHALL override any command: state<=IDLE, read_data<=0, rd_valid=0, ledr<=0, err<=0, access_cnt<=0, and the synchronizer flops SHALL be cleared.
REQ-029 Reset during RD_WAIT or WR SHALL abort the transaction; an aborted read SHALL not update read_data, and RAM contents SHALL be unaffected by reset.

Structure
REQ-030 A shared package cpu_pkg SHALL hold the mem_cmd enum (MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10) and the address constants LED_ADDR=9'h100 and SW_ADDR=9'h140.
REQ-031 The state enum SHALL be local to the block.
REQ-032 The RAM SHALL be a separate sub-module ram_sp (single-port, synchronous write, registered read, 256x16, no reset).

Verification
REQ-033 The bench SHALL check: MWRITE addr 0x005 data 0xBEEF, then MREAD 0x005 -> read_data=0xBEEF with rd_valid pulsed exactly 2 edges after read sample; access_cnt=2.
REQ-034 The bench SHALL check: MWRITE 0x100 data 0x12A5 -> ledr=0xA5 after that edge; a subsequent MREAD 0x100 -> err=1 and read_data=0x0000.
REQ-035 The bench SHALL check: sw=0x3C held, then MREAD 0x140 -> read_data=0x003C; MWRITE 0x140 -> err=1 and ledr unchanged.
REQ-036 The bench SHALL check: MREAD 0x010 (RAM=0x1111), with mem_addr switched to 0x011 during RD_WAIT -> read_data=0x1111.
REQ-037 The bench SHALL check: reset asserted in RD_WAIT -> the next cycle shows IDLE, busy=0, rd_valid=0, read_data=0x0000, and RAM word 0x005 still reads 0xBEEF afterwards.
REQ-038 The bench SHALL check: access_cnt forced near the limit by 65536 MWRITEs to 0x000 -> access_cnt wraps to 0x0000.
